ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/rv32i_types.sv | 86 ++++++++
 rtl/ctrl_decode.sv | 112 +++++++++++
 rtl/ctrl_pipe.sv | 93 +++++++++
 tb/tb_ctrl_pipe.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: opcodes, ALU/compare encodings, mux selects and the
// control word that rides down the pipeline alongside each instruction.
package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops;

   typedef enum logic [2:0] {
      beq  = 3'b000,
      bne  = 3'b001,
      blt  = 3'b100,
      bge  = 3'b101,
      bltu = 3'b110,
      bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic {
      alumux1_rs1 = 1'b0,
      alumux1_pc  = 1'b1
   } alumux1_sel_t;

   typedef enum logic [2:0] {
      alumux2_i_imm = 3'd0,
      alumux2_u_imm = 3'd1,
      alumux2_b_imm = 3'd2,
      alumux2_s_imm = 3'd3,
      alumux2_j_imm = 3'd4,
      alumux2_rs2   = 3'd5
   } alumux2_sel_t;

   typedef enum logic {
      cmpmux_rs2   = 1'b0,
      cmpmux_i_imm = 1'b1
   } cmpmux_sel_t;

   typedef enum logic [2:0] {
      memwb_alu_out   = 3'd0,
      memwb_br_en     = 3'd1,
      memwb_u_imm     = 3'd2,
      memwb_mem_rdata = 3'd3,
      memwb_pc_plus4  = 3'd4
   } memwbmux_sel_t;

   localparam logic [6:0] FUNCT7_M   = 7'b0000001;
   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_SR      = 3'b101;

   typedef struct packed {
      rv32i_opcode    opcode;
      alu_ops         aluop;
      branch_funct3_t cmpop;
      logic [2:0]     funct3;
      alumux1_sel_t   alumux1_sel;
      alumux2_sel_t   alumux2_sel;
      cmpmux_sel_t    cmpmux_sel;
      memwbmux_sel_t  memwbmux_sel;
      logic           load_regfile;
      logic           mem_read;
      logic           mem_write;
      logic           jump;
      logic           mdu;
   } rv32i_control_word;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I(+M) decoder producing the control word for the
// instruction sitting in the decode slot.
module ctrl_decode
   import rv32i_types::*;
#(
   parameter bit ENABLE_M = 1'b0
) (
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [4:0]        rd,
   output rv32i_control_word cword,
   output logic              illegal
);

   // Anything not recognised collapses to an all-zero word so it can never write state.
   always_comb begin
      cword        = '0;
      illegal      = 1'b0;
      cword.opcode = rv32i_opcode'(opcode);
      cword.funct3 = funct3;
      case (rv32i_opcode'(opcode))
         op_lui: begin
            cword.load_regfile = 1'b1;
            cword.memwbmux_sel = memwb_u_imm;
         end
         op_auipc: begin
            cword.alumux1_sel  = alumux1_pc;
            cword.alumux2_sel  = alumux2_u_imm;
            cword.load_regfile = 1'b1;
         end
         op_jal: begin
            cword.alumux1_sel  = alumux1_pc;
            cword.alumux2_sel  = alumux2_j_imm;
            cword.load_regfile = 1'b1;
            cword.jump         = 1'b1;
            cword.memwbmux_sel = memwb_pc_plus4;
         end
         op_jalr: begin
            cword.alumux1_sel  = alumux1_rs1;
            cword.alumux2_sel  = alumux2_i_imm;
            cword.load_regfile = 1'b1;
            cword.jump         = 1'b1;
            cword.memwbmux_sel = memwb_pc_plus4;
         end
         op_br: begin
            cword.cmpop       = branch_funct3_t'(funct3);
            cword.alumux1_sel = alumux1_pc;
            cword.alumux2_sel = alumux2_b_imm;
         end
         op_load: begin
            cword.alumux2_sel  = alumux2_i_imm;
            cword.mem_read     = 1'b1;
            cword.load_regfile = 1'b1;
            cword.memwbmux_sel = memwb_mem_rdata;
         end
         op_store: begin
            cword.alumux2_sel = alumux2_s_imm;
            cword.mem_write   = 1'b1;
         end
         op_imm: begin
            cword.alumux2_sel  = alumux2_i_imm;
            cword.load_regfile = 1'b1;
            case (funct3)
               F3_SLT: begin
                  cword.cmpop        = blt;
                  cword.cmpmux_sel   = cmpmux_i_imm;
                  cword.memwbmux_sel = memwb_br_en;
               end
               F3_SLTU: begin
                  cword.cmpop        = bltu;
                  cword.cmpmux_sel   = cmpmux_i_imm;
                  cword.memwbmux_sel = memwb_br_en;
               end
               F3_SR:   cword.aluop = funct7[5] ? alu_sra : alu_srl;
               default: cword.aluop = alu_ops'(funct3);
            endcase
         end
         op_reg: begin
            cword.alumux2_sel = alumux2_rs2;
            if (funct7 == FUNCT7_M) begin
               if (ENABLE_M) begin
                  cword.mdu          = 1'b1;
                  cword.aluop        = alu_ops'(funct3);
                  cword.load_regfile = 1'b1;
               end else begin
                  illegal = 1'b1;
               end
            end else begin
               cword.load_regfile = 1'b1;
               case (funct3)
                  F3_ADD: cword.aluop = funct7[5] ? alu_sub : alu_add;
                  F3_SLT: begin
                     cword.cmpop        = blt;
                     cword.memwbmux_sel = memwb_br_en;
                  end
                  F3_SLTU: begin
                     cword.cmpop        = bltu;
                     cword.memwbmux_sel = memwb_br_en;
                  end
                  F3_SR:   cword.aluop = funct7[5] ? alu_sra : alu_srl;
                  default: cword.aluop = alu_ops'(funct3);
               endcase
            end
         end
         default: illegal = 1'b1;
      endcase
      if (rd == 5'd0) cword.load_regfile = 1'b0;
      if (illegal) cword = '0;
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline: decodes the ID slot and carries the control word,
// valid bit and rd through NUM_STAGES registered stages with stall/flush/load-use.
module ctrl_pipe
   import rv32i_types::*;
#(
   parameter int NUM_STAGES   = 3,
   parameter int FLUSH_STAGES = 2,
   parameter bit ENABLE_M     = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               id_valid,
   input  logic [6:0]                         opcode,
   input  logic [2:0]                         funct3,
   input  logic [6:0]                         funct7,
   input  logic [4:0]                         rs1,
   input  logic [4:0]                         rs2,
   input  logic [4:0]                         rd,
   input  logic                               stall,
   input  logic                               flush,
   output logic                               id_ready,
   output logic                               illegal,
   output rv32i_control_word [NUM_STAGES-1:0] stage_cword,
   output logic [NUM_STAGES-1:0]              stage_valid,
   output logic [NUM_STAGES-1:0][4:0]         stage_rd
);

   rv32i_control_word                 dec_cword;
   logic                              load_use;
   logic                              s0_valid;
   rv32i_control_word                 s0_cword;
   logic [4:0]                        s0_rd;
   logic [NUM_STAGES-1:0]             nxt_valid;
   rv32i_control_word [NUM_STAGES-1:0] nxt_cword;
   logic [NUM_STAGES-1:0][4:0]        nxt_rd;

   ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
      .opcode  (opcode),
      .funct3  (funct3),
      .funct7  (funct7),
      .rd      (rd),
      .cword   (dec_cword),
      .illegal (illegal)
   );

   // A load in stage 0 cannot forward in time to a dependent instruction in decode.
   assign load_use = stage_valid[0] && stage_cword[0].mem_read && (stage_rd[0] != 5'd0) &&
                     id_valid && ((stage_rd[0] == rs1) || (stage_rd[0] == rs2));
   assign id_ready = !stall && !load_use;

   always_comb begin
      s0_valid = 1'b0;
      s0_cword = '0;
      s0_rd    = '0;
      if (!load_use) begin
         s0_valid = id_valid && !illegal;
         s0_cword = dec_cword;
         s0_rd    = rd;
      end
   end

   // Flush is applied last so it wins over both stall and the load-use bubble.
   always_comb begin
      nxt_valid = stage_valid;
      nxt_cword = stage_cword;
      nxt_rd    = stage_rd;
      if (!stall) begin
         nxt_valid = {stage_valid[NUM_STAGES-2:0], s0_valid};
         nxt_cword = {stage_cword[NUM_STAGES-2:0], s0_cword};
         nxt_rd    = {stage_rd[NUM_STAGES-2:0], s0_rd};
      end
      if (flush) begin
         for (int k = 0; k < FLUSH_STAGES; k++) begin
            nxt_valid[k] = 1'b0;
            nxt_cword[k] = '0;
            nxt_rd[k]    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid <= '0;
         stage_cword <= '0;
         stage_rd    <= '0;
      end else begin
         stage_valid <= nxt_valid;
         stage_cword <= nxt_cword;
         stage_rd    <= nxt_rd;
      end
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios plus randomized traffic checked
// against an instruction-level reference model of the pipeline.
module tb_ctrl_pipe;
   import rv32i_types::*;

   localparam int NS = 3;
   localparam int FS = 2;

   logic clk, rst_n, id_valid, stall, flush;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rs1, rs2, rd;
   logic id_ready, illegal, id_ready_m, illegal_m;
   rv32i_control_word [NS-1:0] stage_cword, stage_cword_m;
   logic [NS-1:0] stage_valid, stage_valid_m;
   logic [NS-1:0][4:0] stage_rd, stage_rd_m;

   int errors = 0;
   int checks = 0;

   ctrl_pipe #(.NUM_STAGES(NS), .FLUSH_STAGES(FS), .ENABLE_M(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .stall(stall), .flush(flush),
      .id_ready(id_ready), .illegal(illegal), .stage_cword(stage_cword),
      .stage_valid(stage_valid), .stage_rd(stage_rd)
   );

   ctrl_pipe #(.NUM_STAGES(NS), .FLUSH_STAGES(FS), .ENABLE_M(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .stall(stall), .flush(flush),
      .id_ready(id_ready_m), .illegal(illegal_m), .stage_cword(stage_cword_m),
      .stage_valid(stage_valid_m), .stage_rd(stage_rd_m)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference decode phrased per instruction class rather than per opcode case.
   function automatic rv32i_control_word ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                                    input logic [6:0] f7, input logic [4:0] rdi,
                                                    input bit en_m, output bit bad);
      rv32i_control_word c;
      bit lui, auipc, jal, jalr, br, ld, st, imm, rg, mext, alu, setlt;
      lui   = (op == 7'h37);
      auipc = (op == 7'h17);
      jal   = (op == 7'h6F);
      jalr  = (op == 7'h67);
      br    = (op == 7'h63);
      ld    = (op == 7'h03);
      st    = (op == 7'h23);
      imm   = (op == 7'h13);
      rg    = (op == 7'h33);
      mext  = rg && (f7 == 7'h01);
      alu   = (imm || rg) && !mext;
      setlt = alu && (f3 == 3'd2 || f3 == 3'd3);
      bad   = !(lui || auipc || jal || jalr || br || ld || st || imm || rg) || (mext && !en_m);
      c = '0;
      if (bad) return c;
      c.opcode      = rv32i_opcode'(op);
      c.funct3      = f3;
      c.alumux1_sel = (auipc || jal || br) ? alumux1_pc : alumux1_rs1;
      c.alumux2_sel = auipc ? alumux2_u_imm : jal ? alumux2_j_imm : br ? alumux2_b_imm :
                      st ? alumux2_s_imm : rg ? alumux2_rs2 : alumux2_i_imm;
      if (mext)                    c.aluop = alu_ops'(f3);
      else if (alu && f3 == 3'd5)  c.aluop = f7[5] ? alu_sra : alu_srl;
      else if (alu && f3 == 3'd0)  c.aluop = (rg && f7[5]) ? alu_sub : alu_add;
      else if (alu && !setlt)      c.aluop = alu_ops'(f3);
      else                         c.aluop = alu_add;
      c.cmpop        = br ? branch_funct3_t'(f3) : setlt ? ((f3 == 3'd2) ? blt : bltu) : beq;
      c.cmpmux_sel   = (setlt && imm) ? cmpmux_i_imm : cmpmux_rs2;
      c.memwbmux_sel = lui ? memwb_u_imm : (jal || jalr) ? memwb_pc_plus4 :
                       ld ? memwb_mem_rdata : setlt ? memwb_br_en : memwb_alu_out;
      c.load_regfile = (lui || auipc || jal || jalr || ld || imm || rg) && (rdi != 5'd0);
      c.mem_read     = ld;
      c.mem_write    = st;
      c.jump         = jal || jalr;
      c.mdu          = mext;
      return c;
   endfunction

   bit                m_valid [NS];
   logic [4:0]        m_rd    [NS];
   rv32i_control_word m_cw    [NS];
   rv32i_control_word mdl_dec;
   bit                mdl_bad, mdl_lu;

   function automatic bit model_load_use();
      return m_valid[0] && m_cw[0].mem_read && (m_rd[0] != 5'd0) && id_valid &&
             ((rs1 == m_rd[0]) || (rs2 == m_rd[0]));
   endfunction

   // Model of the pipeline (ENABLE_M=0): a list of instructions advancing one slot per edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NS; k++) begin
            m_valid[k] = 1'b0;
            m_rd[k]    = '0;
            m_cw[k]    = '0;
         end
      end else begin
         mdl_dec = ref_decode(opcode, funct3, funct7, rd, 1'b0, mdl_bad);
         mdl_lu  = model_load_use();
         if (!stall) begin
            for (int k = NS - 1; k > 0; k--) begin
               m_valid[k] = m_valid[k-1];
               m_rd[k]    = m_rd[k-1];
               m_cw[k]    = m_cw[k-1];
            end
            m_valid[0] = id_valid && !mdl_bad && !mdl_lu;
            m_cw[0]    = mdl_lu ? '0 : mdl_dec;
            m_rd[0]    = mdl_lu ? 5'd0 : rd;
         end
         if (flush) begin
            for (int k = 0; k < FS; k++) begin
               m_valid[k] = 1'b0;
               m_rd[k]    = '0;
               m_cw[k]    = '0;
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d);
      id_valid = v;
      opcode   = op;
      funct3   = f3;
      funct7   = f7;
      rs1      = s1;
      rs2      = s2;
      rd       = d;
   endtask

   task automatic idle(input int n);
      id_valid = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(1'b0, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (stage_valid !== '0) begin
         errors++; $display("[TB] FAIL reset_valid: got %b expected 000", stage_valid);
      end
      checks++;
      if (stage_cword !== '0) begin
         errors++; $display("[TB] FAIL reset_cword: got %h expected 0", stage_cword);
      end
      checks++;
      if (stage_rd !== '0) begin
         errors++; $display("[TB] FAIL reset_rd: got %h expected 0", stage_rd);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7);
      @(negedge clk);
      checks++;
      if (stage_valid[0] !== 1'b1 || stage_rd[0] !== 5'd7) begin
         errors++; $display("[TB] FAIL first_shift: got valid=%b rd=%0d expected valid=1 rd=7",
                            stage_valid[0], stage_rd[0]);
      end
      stall = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (stage_valid !== '0 || stage_cword !== '0 || stage_rd !== '0) begin
         errors++; $display("[TB] FAIL reset_mid_stall: got valid=%b cword=%h rd=%h expected all 0",
                            stage_valid, stage_cword, stage_rd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_flow();
      idle(4);
      drive(1'b1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5);
      for (int c = 0; c < NS; c++) begin
         @(negedge clk);
         id_valid = 1'b0;
         checks++;
         if (stage_valid !== NS'(1 << c)) begin
            errors++; $display("[TB] FAIL flow_valid_c%0d: got %b expected %b", c + 1, stage_valid,
                               NS'(1 << c));
         end
         checks++;
         if ({stage_rd[c], stage_cword[c].load_regfile, stage_cword[c].aluop} !==
             {5'd5, 1'b1, alu_add}) begin
            errors++; $display("[TB] FAIL flow_fields_s%0d: got rd=%0d ld=%b aluop=%0d expected rd=5 ld=1 aluop=0",
                               c, stage_rd[c], stage_cword[c].load_regfile, stage_cword[c].aluop);
         end
      end
   endtask

   task automatic test_load_use();
      idle(4);
      drive(1'b1, 7'h03, 3'd2, 7'd0, 5'd1, 5'd0, 5'd3);
      @(negedge clk);
      drive(1'b1, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd4);
      #1;
      checks++;
      if (id_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL lu_ready_low: got %b expected 0", id_ready);
      end
      @(negedge clk);
      checks++;
      if (stage_valid[0] !== 1'b0 || stage_cword[0] !== '0) begin
         errors++; $display("[TB] FAIL lu_bubble: got valid=%b cword=%h expected valid=0 cword=0",
                            stage_valid[0], stage_cword[0]);
      end
      checks++;
      if (stage_valid[1] !== 1'b1 || stage_cword[1].mem_read !== 1'b1 || stage_rd[1] !== 5'd3) begin
         errors++; $display("[TB] FAIL lu_load_s1: got valid=%b rd=%b rdidx=%0d expected 1 1 3",
                            stage_valid[1], stage_cword[1].mem_read, stage_rd[1]);
      end
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL lu_ready_high: got %b expected 1", id_ready);
      end
      @(negedge clk);
      id_valid = 1'b0;
      checks++;
      if (stage_valid[0] !== 1'b1 || stage_rd[0] !== 5'd4 || stage_valid[1] !== 1'b0) begin
         errors++; $display("[TB] FAIL lu_add_enters: got v0=%b rd0=%0d v1=%b expected 1 4 0",
                            stage_valid[0], stage_rd[0], stage_valid[1]);
      end
   endtask

   task automatic test_flush_stall();
      idle(4);
      for (int r = 1; r <= NS; r++) begin
         drive(1'b1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'(r));
         @(negedge clk);
      end
      checks++;
      if (stage_valid !== '1 || stage_rd !== {5'd1, 5'd2, 5'd3}) begin
         errors++; $display("[TB] FAIL fs_fill: got valid=%b rd=%h expected 111 rd=%h",
                            stage_valid, stage_rd, {5'd1, 5'd2, 5'd3});
      end
      stall = 1'b1;
      flush = 1'b1;
      drive(1'b1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9);
      @(negedge clk);
      checks++;
      if (stage_valid !== 3'b100 || stage_cword[0] !== '0 || stage_cword[1] !== '0) begin
         errors++; $display("[TB] FAIL fs_killed: got valid=%b cw0=%h cw1=%h expected 100 0 0",
                            stage_valid, stage_cword[0], stage_cword[1]);
      end
      checks++;
      if ({stage_rd[2], stage_cword[2].load_regfile, stage_cword[2].aluop} !== {5'd1, 1'b1, alu_add}) begin
         errors++; $display("[TB] FAIL fs_held_s2: got rd=%0d ld=%b aluop=%0d expected rd=1 ld=1 aluop=0",
                            stage_rd[2], stage_cword[2].load_regfile, stage_cword[2].aluop);
      end
      idle(1);
   endtask

   task automatic test_illegal_m();
      idle(4);
      drive(1'b1, 7'h7F, 3'd0, 7'd0, 5'd1, 5'd1, 5'd2);
      #1;
      checks++;
      if (illegal !== 1'b1 || illegal_m !== 1'b1) begin
         errors++; $display("[TB] FAIL ill_7f_flag: got %b/%b expected 1/1", illegal, illegal_m);
      end
      @(negedge clk);
      checks++;
      if (stage_valid[0] !== 1'b0) begin
         errors++; $display("[TB] FAIL ill_7f_stage: got valid=%b expected 0", stage_valid[0]);
      end
      drive(1'b1, 7'h33, 3'd0, 7'h01, 5'd2, 5'd3, 5'd1);
      #1;
      checks++;
      if (illegal !== 1'b1 || illegal_m !== 1'b0) begin
         errors++; $display("[TB] FAIL mul_flag: got noM=%b M=%b expected 1/0", illegal, illegal_m);
      end
      @(negedge clk);
      id_valid = 1'b0;
      checks++;
      if (stage_valid[0] !== 1'b0) begin
         errors++; $display("[TB] FAIL mul_noM_stage: got valid=%b expected 0", stage_valid[0]);
      end
      checks++;
      if ({stage_valid_m[0], stage_cword_m[0].mdu, stage_cword_m[0].aluop,
           stage_cword_m[0].load_regfile} !== {1'b1, 1'b1, 3'd0, 1'b1}) begin
         errors++; $display("[TB] FAIL mul_M_stage: got v=%b mdu=%b aluop=%0d ld=%b expected 1 1 0 1",
                            stage_valid_m[0], stage_cword_m[0].mdu, stage_cword_m[0].aluop,
                            stage_cword_m[0].load_regfile);
      end
   endtask

   task automatic test_rd0();
      idle(2);
      drive(1'b1, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (illegal !== 1'b0) begin
         errors++; $display("[TB] FAIL jal_flag: got %b expected 0", illegal);
      end
      @(negedge clk);
      id_valid = 1'b0;
      checks++;
      if ({stage_valid[0], stage_cword[0].jump, stage_cword[0].load_regfile,
           stage_cword[0].memwbmux_sel} !== {1'b1, 1'b1, 1'b0, memwb_pc_plus4}) begin
         errors++; $display("[TB] FAIL jal_x0: got v=%b jump=%b ld=%b wb=%0d expected 1 1 0 4",
                            stage_valid[0], stage_cword[0].jump, stage_cword[0].load_regfile,
                            stage_cword[0].memwbmux_sel);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [13];
      rv32i_control_word dc;
      bit bad, bad_m;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33,
              7'h7F, 7'h00, 7'h73};
      idle(4);
      for (int it = 0; it < 400; it++) begin
         for (int k = 0; k < NS; k++) begin
            checks++;
            if (stage_valid[k] !== m_valid[k]) begin
               errors++; $display("[TB] FAIL rnd_valid it=%0d s%0d: got %b expected %b",
                                  it, k, stage_valid[k], m_valid[k]);
            end
            if (m_valid[k]) begin
               checks++;
               if (stage_cword[k] !== m_cw[k] || stage_rd[k] !== m_rd[k]) begin
                  errors++; $display("[TB] FAIL rnd_word it=%0d s%0d: got cw=%h rd=%0d expected cw=%h rd=%0d",
                                     it, k, stage_cword[k], stage_rd[k], m_cw[k], m_rd[k]);
               end
            end
         end
         opcode = ops[$urandom_range(0, 12)];
         funct3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       funct7 = 7'h00;
            1:       funct7 = 7'h20;
            2:       funct7 = 7'h01;
            default: funct7 = 7'($urandom_range(0, 127));
         endcase
         rs1      = 5'($urandom_range(0, 5));
         rs2      = 5'($urandom_range(0, 5));
         rd       = 5'($urandom_range(0, 5));
         id_valid = ($urandom_range(0, 4) != 0);
         stall    = ($urandom_range(0, 9) == 0);
         flush    = ($urandom_range(0, 11) == 0);
         #1;
         dc = ref_decode(opcode, funct3, funct7, rd, 1'b0, bad);
         dc = ref_decode(opcode, funct3, funct7, rd, 1'b1, bad_m);
         checks++;
         if (id_ready !== (!stall && !model_load_use())) begin
            errors++; $display("[TB] FAIL rnd_ready it=%0d: got %b expected %b",
                               it, id_ready, !stall && !model_load_use());
         end
         checks++;
         if (illegal !== bad || illegal_m !== bad_m) begin
            errors++; $display("[TB] FAIL rnd_illegal it=%0d: got %b/%b expected %b/%b",
                               it, illegal, illegal_m, bad, bad_m);
         end
         @(negedge clk);
      end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_flow();
      test_load_use();
      test_flush_stall();
      test_illegal_m();
      test_rd0();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
